toggle_period_meter: RTL and testbench
======================================

Name: toggle_period_meter

Overview:
- Downstream consumer of the LED toggle generator's square-wave output (or any slow toggling signal).
- Synchronises the input and detects both edges. Measures the half-period in pi_clk cycles and presents each result on a valid/ready output.
- Flags loss of toggling with a timeout. Used on-board to verify divider settings without a scope.

Parameters:
CNT_W, 32, width of period counter and po_period
TIMEOUT, 50000000, cycles without an edge before po_timeout asserts; 0 disables timeout
SYNC_STAGES, 2, synchroniser depth on pi_signal (min 2)

Ports:
pi_clk  input  1  system clock
pi_rstn  input  1  reset, asynchronous, active-low
pi_signal  input  1  asynchronous toggling input under test
pi_enable  input  1  measurement enable, synchronous to pi_clk
po_period  output  CNT_W  last measured half-period in pi_clk cycles
po_valid  output  1  po_period holds an unconsumed result
pi_ready  input  1  consumer accepts result when po_valid && pi_ready
po_timeout  output  1  no edge for TIMEOUT cycles; held until next edge
po_edge_count  output  16  saturating count of detected edges since enable rose

Behaviour:
- Reset, asynchronous on pi_rstn low:
  - po_period=0, po_valid=0, po_timeout=0, po_edge_count=0.
  - Synchroniser and previous-level registers = 0; counter = 0; FSM = IDLE.
- Edge detect: edge = sync_out ^ prev, where prev is sync_out delayed one cycle. Both rising and falling edges count.
- Latency: po_valid rises on the SYNC_STAGES-th pi_clk rising edge after the edge that first samples the new pi_signal level (2 cycles at default).
- FSM:
  - IDLE: counter held at 0; edges ignored. On pi_enable=1 -> ARM, and po_edge_count cleared.
  - ARM: waiting for first edge. On edge -> MEASURE, counter=0, no capture.
  - MEASURE: counter increments each cycle, saturating at 2^CNT_W-1.
    - On edge: capture po_period = min(counter+1, 2^CNT_W-1); counter=0; stay in MEASURE.
    - If TIMEOUT!=0 and counter reaches TIMEOUT-1 with no edge -> TIMEOUT, po_timeout=1.
  - TIMEOUT: on edge -> MEASURE, counter=0, po_timeout=0, no capture, because the half-period is unknown.
  - Any state with pi_enable=0 -> IDLE next cycle. A pending po_valid/po_period is kept until consumed. po_timeout cleared.
- Meaning of the result: an input that toggles every N cycles yields po_period=N.
- Handshake:
  - po_valid set on capture; cleared on the cycle after po_valid && pi_ready.
  - po_period stable while po_valid=1 and not accepted, except for the overwrite case under Optional Feature.
  - Capture and acceptance in the same cycle: new result is loaded and po_valid stays 1.
- po_edge_count: +1 per detected edge while in ARM, MEASURE or TIMEOUT; saturates at 16'hFFFF.
- Edge and timeout threshold in the same cycle: edge wins (capture, no timeout).
- Reset mid-operation: all state returns to reset values immediately; no result is produced from a partial count.

Optional Feature:
- Macro: TOGGLE_PERIOD_METER_HOLD_EN.
- Defined: a capture while po_valid=1 and not accepted this cycle is dropped; po_period keeps the older result.
- Undefined: the capture overwrites po_period (newest result wins); po_valid stays 1.
- The counter and FSM behave identically in both builds.

Test Plan:
- Toggle every 5 cycles, pi_ready=1, pi_enable=1 -> first edge only arms; every following edge gives a 1-cycle po_valid pulse with po_period=5; latency 2 cycles at SYNC_STAGES=2.
- TIMEOUT=100; one edge, then pi_signal held for 150 cycles -> po_timeout=1 on counter reaching 99. The next edge clears it with no po_valid; the following edge 12 cycles later -> po_period=12.
- pi_ready=0; half-periods 7 then 9 -> undefined build: po_period=9, po_valid held high. HOLD_EN build: po_period=7. Then pi_ready=1 for one cycle -> po_valid=0 next cycle.
- Async reset: pulse pi_rstn low between clock edges mid-MEASURE with po_valid=1 -> all outputs 0 without a clock. After release, the first edge does not capture.
- pi_enable=0 during toggling -> po_edge_count frozen, no captures. Re-enable -> po_edge_count=0, first edge arms, second edge captures the correct period.
- CNT_W=4, TIMEOUT=0, toggle every 20 cycles -> po_period=15 (saturated); po_timeout never asserts.

Source files
------------

// File: rtl/toggle_period_meter.sv
// toggle_period_meter
//
// Measures the half-period of a slow, asynchronous toggling signal in pi_clk
// cycles. The input is synchronised, both edges are detected, and each
// measured half-period is offered on a valid/ready output. A timeout flags
// loss of toggling, and a saturating counter reports edges seen since the
// last enable.
//
// Optional build macro: TOGGLE_PERIOD_METER_HOLD_EN
//   defined   - a capture that arrives while an unaccepted result is pending
//               is dropped (oldest result is kept)
//   undefined - the capture overwrites the pending result (newest wins)
//
// Ports:
//   pi_clk         system clock
//   pi_rstn        asynchronous active-low reset
//   pi_signal      asynchronous toggling input under test
//   pi_enable      measurement enable (pi_clk domain)
//   po_period      last measured half-period, CNT_W bits
//   po_valid       po_period holds an unconsumed result
//   pi_ready       consumer accepts the result when po_valid && pi_ready
//   po_timeout     no edge for TIMEOUT cycles; held until the next edge
//   po_edge_count  saturating count of edges since enable rose
//
// State | meaning
// IDLE    | disabled; counter held at 0, edges ignored
// ARM     | enabled, waiting for the first edge to start a measurement
// MEASURE | counting cycles since the last edge; each edge captures a result
// TMO     | no edge for TIMEOUT cycles; next edge restarts without capture

module toggle_period_meter #(
    parameter int          CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 50000000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             pi_clk,
    input  logic             pi_rstn,
    input  logic             pi_signal,
    input  logic             pi_enable,
    output logic [CNT_W-1:0] po_period,
    output logic             po_valid,
    input  logic             pi_ready,
    output logic             po_timeout,
    output logic [15:0]      po_edge_count
);

    // A single flop is not a synchroniser; depths below two are clamped.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Compared in 64 bits so a TIMEOUT larger than the counter range simply
    // never fires instead of aliasing onto a truncated value.
    localparam logic [63:0]      TO_LAST = 64'(TIMEOUT) - 64'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        TMO     = 2'd3
    } state_t;

    state_t           state;
    logic [SYNC_N-1:0] sync_q;
    logic             prev_q;
    logic [CNT_W-1:0] counter;

    logic             sync_out;
    logic             edge_seen;
    logic             accept;
    logic             capture;
    logic             load_ok;
    logic             timeout_hit;
    logic [CNT_W-1:0] cap_val;

    assign sync_out    = sync_q[SYNC_N-1];
    assign edge_seen   = sync_out ^ prev_q;
    assign accept      = po_valid && pi_ready;
    assign capture     = pi_enable && (state == MEASURE) && edge_seen;
    assign timeout_hit = (TIMEOUT != 0) && (64'(counter) == TO_LAST);
    assign cap_val     = (counter == CNT_MAX) ? CNT_MAX : counter + CNT_W'(1);

`ifdef TOGGLE_PERIOD_METER_HOLD_EN
    assign load_ok = !(po_valid && !pi_ready);
`else
    assign load_ok = 1'b1;
`endif

    always_ff @(posedge pi_clk or negedge pi_rstn) begin
        if (!pi_rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], pi_signal};
            prev_q <= sync_out;
        end
    end

    always_ff @(posedge pi_clk or negedge pi_rstn) begin
        if (!pi_rstn) begin
            state         <= IDLE;
            counter       <= '0;
            po_timeout    <= 1'b0;
            po_edge_count <= '0;
        end else if (!pi_enable) begin
            state      <= IDLE;
            counter    <= '0;
            po_timeout <= 1'b0;
        end else begin
            if (state != IDLE && edge_seen && po_edge_count != 16'hFFFF)
                po_edge_count <= po_edge_count + 16'd1;
            case (state)
                IDLE: begin
                    state         <= ARM;
                    counter       <= '0;
                    po_edge_count <= '0;
                end
                ARM: begin
                    if (edge_seen) begin
                        state   <= MEASURE;
                        counter <= '0;
                    end
                end
                MEASURE: begin
                    // An edge on the threshold cycle is a valid measurement.
                    if (edge_seen) begin
                        counter <= '0;
                    end else if (timeout_hit) begin
                        state      <= TMO;
                        po_timeout <= 1'b1;
                    end else if (counter != CNT_MAX) begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                TMO: begin
                    if (edge_seen) begin
                        state      <= MEASURE;
                        counter    <= '0;
                        po_timeout <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The result register lives outside the enable gating so a pending
    // result survives a disable until the consumer takes it.
    always_ff @(posedge pi_clk or negedge pi_rstn) begin
        if (!pi_rstn) begin
            po_period <= '0;
            po_valid  <= 1'b0;
        end else if (capture && load_ok) begin
            po_period <= cap_val;
            po_valid  <= 1'b1;
        end else if (accept) begin
            po_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Testbench for toggle_period_meter.
// Instance a: CNT_W=32, TIMEOUT=100. Instance b: CNT_W=4, TIMEOUT=0.
// Expected results are derived from the intervals between the bench's own
// toggles: the first toggle after enable/reset only arms; each later toggle
// N cycles after the previous one yields min(N, 2^CNT_W-1), unless N exceeds
// TIMEOUT, in which case the meter timed out and that toggle yields nothing.
// Results are expected to appear two cycles after the toggle is first sampled.

module tb_toggle_period_meter;

    localparam int TMO = 100;

    typedef struct {
        longint period;
        int     cyc;   // 0 = arrival cycle not checked
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        sig_a, en_a, rdy_a;
    logic [31:0] pa;
    logic        va, toa;
    logic [15:0] eca;
    logic        sig_b, en_b, rdy_b;
    logic [3:0]  pb;
    logic        vb, tob;
    logic [15:0] ecb;

    toggle_period_meter #(.CNT_W(32), .TIMEOUT(TMO), .SYNC_STAGES(2)) dut_a (
        .pi_clk(clk), .pi_rstn(rstn), .pi_signal(sig_a), .pi_enable(en_a),
        .po_period(pa), .po_valid(va), .pi_ready(rdy_a), .po_timeout(toa),
        .po_edge_count(eca)
    );

    toggle_period_meter #(.CNT_W(4), .TIMEOUT(0), .SYNC_STAGES(2)) dut_b (
        .pi_clk(clk), .pi_rstn(rstn), .pi_signal(sig_b), .pi_enable(en_b),
        .po_period(pb), .po_valid(vb), .pi_ready(rdy_b), .po_timeout(tob),
        .po_edge_count(ecb)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t qa[$];
    exp_t qb[$];

    // reference model state
    bit   en_m;
    bit   armed_a, armed_b;
    int   last_a, last_b;
    int   ecount;
    bit   to_b_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitors: a result is consumed when valid && ready
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rstn && va && rdy_a) begin
            n_cmp++;
            if (qa.size() == 0) begin
                n_bad++;
                $display("FAIL a_result: got unexpected period %0d, expected no result (cycle %0d)", pa, cyc);
            end else begin
                e = qa.pop_front();
                if (64'(pa) != e.period || (e.cyc != 0 && cyc != e.cyc)) begin
                    n_bad++;
                    $display("FAIL a_result: got period %0d at cycle %0d, expected %0d at cycle %0d",
                             pa, cyc, e.period, e.cyc);
                end
            end
        end
        if (rstn && vb && rdy_b) begin
            n_cmp++;
            if (qb.size() == 0) begin
                n_bad++;
                $display("FAIL b_result: got unexpected period %0d, expected no result (cycle %0d)", pb, cyc);
            end else begin
                e = qb.pop_front();
                if (64'(pb) != e.period || (e.cyc != 0 && cyc != e.cyc)) begin
                    n_bad++;
                    $display("FAIL b_result: got period %0d at cycle %0d, expected %0d at cycle %0d",
                             pb, cyc, e.period, e.cyc);
                end
            end
        end
        if (tob) to_b_seen = 1'b1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the new level is sampled at posedge e0.
    task automatic toggle_a(input bit push_en);
        int e0 = cyc + 1;
        int n;
        sig_a = ~sig_a;
        if (en_m) begin
            n = e0 - last_a;
            if (armed_a && push_en && n <= TMO)
                qa.push_back('{period: longint'(n), cyc: e0 + 2});
            armed_a = 1'b1;
            last_a  = e0;
            if (ecount < 65535) ecount++;
        end
    endtask

    task automatic toggle_b();
        int e0 = cyc + 1;
        int n  = e0 - last_b;
        sig_b = ~sig_b;
        if (armed_b)
            qb.push_back('{period: longint'((n > 15) ? 15 : n), cyc: e0 + 2});
        armed_b = 1'b1;
        last_b  = e0;
    endtask

    task automatic run_a(input int n);
        idle(n);
        toggle_a(1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        longint hold_exp;
        logic [15:0] frozen;

        rstn  = 1'b0;
        sig_a = 1'b0; en_a = 1'b1; rdy_a = 1'b1;
        sig_b = 1'b0; en_b = 1'b1; rdy_b = 1'b1;
        en_m = 1'b1; armed_a = 1'b0; armed_b = 1'b0;
        last_a = 0; last_b = 0; ecount = 0;

        #1;
        check("rst_period", 64'(pa), 0);
        check("rst_valid", 64'(va), 0);
        check("rst_timeout", 64'(toa), 0);
        check("rst_edge_count", 64'(eca), 0);
        idle(2);
        rstn = 1'b1;
        idle(2);

        // steady toggle every 5 cycles: first edge only arms
        toggle_a(1'b1);
        for (int i = 0; i < 8; i++) run_a(5);
        idle(4);
        check("edge_count_basic", 64'(eca), 64'(ecount));

        // timeout: one edge, then hold for 150 cycles
        idle(3);
        toggle_a(1'b1);
        e0 = last_a;
        while (cyc < e0 + 1 + TMO) @(negedge clk);
        check("timeout_before", 64'(toa), 0);
        idle(1);
        check("timeout_asserted", 64'(toa), 1);
        while (cyc < e0 + 149) @(negedge clk);
        check("timeout_held", 64'(toa), 1);
        toggle_a(1'b1);
        idle(2);
        check("timeout_until_edge", 64'(toa), 1);
        idle(1);
        check("timeout_cleared", 64'(toa), 0);
        idle(9);
        toggle_a(1'b1);
        idle(4);

        // edge exactly on the timeout threshold wins
        toggle_a(1'b1);
        idle(100);
        toggle_a(1'b1);
        idle(3);
        check("edge_wins_timeout", 64'(toa), 0);
        idle(98);
        toggle_a(1'b1);
        run_a(3);
        idle(4);

        // back-pressure: 7 then 9 while not ready
        toggle_a(1'b1);
        idle(4);
        rdy_a = 1'b0;
        idle(3);
        toggle_a(1'b0);
        idle(9);
        toggle_a(1'b0);
        idle(4);
`ifdef TOGGLE_PERIOD_METER_HOLD_EN
        hold_exp = 7;
`else
        hold_exp = 9;
`endif
        check("hold_valid", 64'(va), 1);
        check("hold_period", 64'(pa), 64'(hold_exp));
        qa.push_back('{period: hold_exp, cyc: 0});
        rdy_a = 1'b1;
        idle(1);
        rdy_a = 1'b0;
        check("valid_after_accept", 64'(va), 0);
        rdy_a = 1'b1;
        idle(2);

        // async reset mid-measure with a pending result
        toggle_a(1'b1);
        idle(4);
        rdy_a = 1'b0;
        idle(1);
        toggle_a(1'b0);
        idle(6);
        check("pre_reset_valid", 64'(va), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_period", 64'(pa), 0);
        check("async_rst_valid", 64'(va), 0);
        check("async_rst_timeout", 64'(toa), 0);
        check("async_rst_edge_count", 64'(eca), 0);
        sig_a = 1'b0;
        rdy_a = 1'b1;
        armed_a = 1'b0;
        ecount = 0;
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
        toggle_a(1'b1);
        run_a(6);
        idle(4);
        check("edge_count_after_reset", 64'(eca), 64'(ecount));

        // disable while toggling, then re-enable
        frozen = eca;
        en_a = 1'b0;
        en_m = 1'b0;
        for (int i = 0; i < 5; i++) run_a(4);
        idle(3);
        check("edge_count_frozen", 64'(eca), 64'(frozen));
        check("timeout_off_when_disabled", 64'(toa), 0);
        en_a = 1'b1;
        en_m = 1'b1;
        armed_a = 1'b0;
        ecount = 0;
        idle(2);
        check("edge_count_cleared", 64'(eca), 0);
        toggle_a(1'b1);
        run_a(11);
        idle(4);
        check("edge_count_reenabled", 64'(eca), 64'(ecount));

        // randomized intervals, occasionally past the timeout
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) run_a(int'($urandom_range(95, 130)));
            else                           run_a(int'($urandom_range(1, 40)));
        end
        idle(4);
        check("edge_count_random", 64'(eca), 64'(ecount));

        // narrow counter, timeout disabled: saturation
        toggle_b();
        for (int i = 0; i < 4; i++) begin
            idle(20);
            toggle_b();
        end
        for (int i = 0; i < 20; i++) begin
            idle(int'($urandom_range(1, 40)));
            toggle_b();
        end
        idle(6);

        check("a_queue_drained", 64'(qa.size()), 0);
        check("b_queue_drained", 64'(qb.size()), 0);
        check("b_timeout_never", 64'(to_b_seen), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
